// File: rtl/register_window_controller.sv
// SPARC register-window sequencer: owns CWP and WIM, runs SAVE/RESTORE/trap/RETT
// moves through IDLE->CHECK->RESP, and maps architectural to physical register indices.
module register_window_controller #(
  parameter int NWINDOWS = 8,
  parameter int CWP_W    = 3,
  parameter int PHYS_W   = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Save_Req,
  input  logic                Restore_Req,
  input  logic                Trap_Req,
  input  logic                Rett_Req,
  input  logic                Cwp_Write,
  input  logic [CWP_W-1:0]    Cwp_Data,
  input  logic                Wim_Write,
  input  logic [NWINDOWS-1:0] Wim_Data,
  input  logic [4:0]          Rs1_Arch,
  input  logic [4:0]          Rs2_Arch,
  input  logic [4:0]          Rd_Arch,
  output logic [PHYS_W-1:0]   Rs1_Phys,
  output logic [PHYS_W-1:0]   Rs2_Phys,
  output logic [PHYS_W-1:0]   Rd_Phys,
  output logic [CWP_W-1:0]    Cwp,
  output logic [NWINDOWS-1:0] Wim,
  output logic                Busy,
  output logic                Done,
  output logic                Window_Overflow,
  output logic                Window_Underflow
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RESP} state_t;
  typedef enum logic [1:0] {K_SAVE, K_RESTORE, K_TRAP, K_RETT} kind_t;

  localparam logic [CWP_W:0] NW_L = NWINDOWS[CWP_W:0];

  state_t                r_state;
  kind_t                 r_kind;
  logic [CWP_W-1:0]      r_cwp;
  logic [CWP_W-1:0]      r_target;
  logic [NWINDOWS-1:0]   r_wim;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_ovf;
  logic                  r_unf;
  logic                  w_any_req;
  logic                  w_cwp_ok;

  assign w_any_req = Trap_Req | Rett_Req | Save_Req | Restore_Req;
  assign w_cwp_ok  = ({1'b0, Cwp_Data} < NW_L);

  // Windowed registers wrap modulo 16*NWINDOWS, a power of two, so the
  // CWP_W+4 bit sum truncates to the required modulus.
  function automatic logic [PHYS_W-1:0] map_reg(input logic [4:0] r, input logic [CWP_W-1:0] cwp);
    logic [CWP_W+3:0]  w_ext;
    logic [CWP_W+3:0]  w_sum;
    logic [PHYS_W-1:0] w_p;
    w_p = '0;
    if (r[4:3] == 2'b00) begin
      w_p[4:0] = r;
    end else begin
      w_ext      = '0;
      w_ext[4:0] = r - 5'd8;
      w_sum      = {cwp, 4'b0000} + w_ext;
      w_p[CWP_W+3:0] = w_sum;
      w_p        = w_p + PHYS_W'(8);
    end
    return w_p;
  endfunction

  always_comb begin
    Rs1_Phys = map_reg(Rs1_Arch, r_cwp);
    Rs2_Phys = map_reg(Rs2_Arch, r_cwp);
    Rd_Phys  = map_reg(Rd_Arch, r_cwp);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_kind   <= K_SAVE;
      r_cwp    <= '0;
      r_target <= '0;
      r_wim    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Wim_Write) r_wim <= Wim_Data;
          if (w_any_req) begin
            r_state <= S_CHECK;
            r_busy  <= 1'b1;
            if (Trap_Req) begin
              r_kind   <= K_TRAP;
              r_target <= r_cwp - 1'b1;
            end else if (Rett_Req) begin
              r_kind   <= K_RETT;
              r_target <= r_cwp + 1'b1;
            end else if (Save_Req) begin
              r_kind   <= K_SAVE;
              r_target <= r_cwp - 1'b1;
            end else begin
              r_kind   <= K_RESTORE;
              r_target <= r_cwp + 1'b1;
            end
          end else if (Cwp_Write && w_cwp_ok) begin
            r_cwp <= Cwp_Data;
          end
        end
        S_CHECK: begin
          r_state <= S_RESP;
          case (r_kind)
            K_TRAP: begin
              r_cwp  <= r_target;
              r_done <= 1'b1;
            end
            K_SAVE: begin
              if (r_wim[r_target]) begin
                r_ovf <= 1'b1;
              end else begin
                r_cwp  <= r_target;
                r_done <= 1'b1;
              end
            end
            default: begin
              if (r_wim[r_target]) begin
                r_unf <= 1'b1;
              end else begin
                r_cwp  <= r_target;
                r_done <= 1'b1;
              end
            end
          endcase
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Cwp              = r_cwp;
  assign Wim              = r_wim;
  assign Busy             = r_busy;
  assign Done             = r_done;
  assign Window_Overflow  = r_ovf;
  assign Window_Underflow = r_unf;

endmodule

// File: tb/tb_register_window_controller.sv
// Directed bench for register_window_controller: window moves, WIM faults,
// priority, busy-time filtering, mid-operation reset and index mapping.
module tb_register_window_controller;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Save_Req = 1'b0, Restore_Req = 1'b0, Trap_Req = 1'b0, Rett_Req = 1'b0;
  logic       Cwp_Write = 1'b0;
  logic [2:0] Cwp_Data = '0;
  logic       Wim_Write = 1'b0;
  logic [7:0] Wim_Data = '0;
  logic [4:0] Rs1_Arch = '0, Rs2_Arch = '0, Rd_Arch = '0;
  logic [7:0] Rs1_Phys, Rs2_Phys, Rd_Phys;
  logic [2:0] Cwp;
  logic [7:0] Wim;
  logic       Busy, Done, Window_Overflow, Window_Underflow;

  int checks = 0;
  int failures = 0;

  register_window_controller #(.NWINDOWS(8), .CWP_W(3), .PHYS_W(8)) dut (
    .Clk(Clk), .Reset(Reset),
    .Save_Req(Save_Req), .Restore_Req(Restore_Req), .Trap_Req(Trap_Req), .Rett_Req(Rett_Req),
    .Cwp_Write(Cwp_Write), .Cwp_Data(Cwp_Data), .Wim_Write(Wim_Write), .Wim_Data(Wim_Data),
    .Rs1_Arch(Rs1_Arch), .Rs2_Arch(Rs2_Arch), .Rd_Arch(Rd_Arch),
    .Rs1_Phys(Rs1_Phys), .Rs2_Phys(Rs2_Phys), .Rd_Phys(Rd_Phys),
    .Cwp(Cwp), .Wim(Wim), .Busy(Busy), .Done(Done),
    .Window_Overflow(Window_Overflow), .Window_Underflow(Window_Underflow)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic b, input logic d, input logic o, input logic u);
    check({tag, "_busy"}, 32'(Busy), 32'(b));
    check({tag, "_done"}, 32'(Done), 32'(d));
    check({tag, "_ovf"},  32'(Window_Overflow), 32'(o));
    check({tag, "_unf"},  32'(Window_Underflow), 32'(u));
  endtask

  task automatic set_cwp(input logic [2:0] v);
    Cwp_Data = v; Cwp_Write = 1'b1;
    tick();
    Cwp_Write = 1'b0;
  endtask

  task automatic set_wim(input logic [7:0] v);
    Wim_Data = v; Wim_Write = 1'b1;
    tick();
    Wim_Write = 1'b0;
  endtask

  initial begin
    tick(); tick();
    Reset = 1'b0;
    check("rst_cwp", 32'(Cwp), 0);
    check("rst_wim", 32'(Wim), 0);
    check_flags("rst", 0, 0, 0, 0);
    Rs1_Arch = 5'd5; Rs2_Arch = 5'd8; Rd_Arch = 5'd31;
    #1;
    check("map0_rs1", 32'(Rs1_Phys), 5);
    check("map0_rs2", 32'(Rs2_Phys), 8);
    check("map0_rd",  32'(Rd_Phys), 31);

    // SAVE from window 0 wraps to window 7
    Save_Req = 1'b1; tick(); Save_Req = 1'b0;
    check_flags("save_c1", 1, 0, 0, 0);
    check("save_c1_cwp", 32'(Cwp), 0);
    tick();
    check_flags("save_c2", 1, 1, 0, 0);
    check("save_cwp", 32'(Cwp), 7);
    Rd_Arch = 5'd31; #1;
    check("map7_r31", 32'(Rd_Phys), 15);
    Rd_Arch = 5'd24; #1;
    check("map7_r24", 32'(Rd_Phys), 8);
    tick();
    check_flags("save_idle", 0, 0, 0, 0);

    // Overflow then trap that ignores WIM
    set_cwp(3'd0);
    check("cwpw0", 32'(Cwp), 0);
    check_flags("cwpw0", 0, 0, 0, 0);
    set_wim(8'h80);
    check("wim80", 32'(Wim), 32'h80);
    Save_Req = 1'b1; tick(); Save_Req = 1'b0;
    tick();
    check_flags("ovf", 1, 0, 1, 0);
    check("ovf_cwp", 32'(Cwp), 0);
    tick();
    Trap_Req = 1'b1; tick(); Trap_Req = 1'b0;
    tick();
    check_flags("trap", 1, 1, 0, 0);
    check("trap_cwp", 32'(Cwp), 7);
    tick();

    // Underflow on RESTORE, then RETT wraps 7 -> 0
    set_wim(8'h01);
    Restore_Req = 1'b1; tick(); Restore_Req = 1'b0;
    tick();
    check_flags("unf", 1, 0, 0, 1);
    check("unf_cwp", 32'(Cwp), 7);
    tick();
    set_wim(8'h00);
    Rett_Req = 1'b1; tick(); Rett_Req = 1'b0;
    tick();
    check_flags("rett", 1, 1, 0, 0);
    check("rett_cwp", 32'(Cwp), 0);
    tick();

    // SAVE beats RESTORE; SAVE during busy is dropped
    set_cwp(3'd3);
    Save_Req = 1'b1; Restore_Req = 1'b1; tick(); Restore_Req = 1'b0;
    check("prio_busy", 32'(Busy), 1);
    tick(); Save_Req = 1'b0;
    check_flags("prio", 1, 1, 0, 0);
    check("prio_cwp", 32'(Cwp), 2);
    tick();
    check_flags("prio_after1", 0, 0, 0, 0);
    tick();
    check_flags("prio_after2", 0, 0, 0, 0);
    check("prio_cwp_hold", 32'(Cwp), 2);

    // WIM write while busy is ignored
    Restore_Req = 1'b1; tick(); Restore_Req = 1'b0;
    set_wim(8'hFF);
    tick();
    check("busy_wim", 32'(Wim), 0);
    check("busy_restore_cwp", 32'(Cwp), 3);

    // Reset during CHECK aborts the move
    set_cwp(3'd4);
    check("cwpw4", 32'(Cwp), 4);
    Save_Req = 1'b1; tick(); Save_Req = 1'b0;
    Reset = 1'b1; tick(); Reset = 1'b0;
    check("abort_cwp", 32'(Cwp), 0);
    check_flags("abort", 0, 0, 0, 0);
    tick();
    check_flags("abort_after", 0, 0, 0, 0);
    set_cwp(3'd5);
    check("cwpw5", 32'(Cwp), 5);
    check_flags("cwpw5", 0, 0, 0, 0);
    Rs1_Arch = 5'd16; Rs2_Arch = 5'd8; Rd_Arch = 5'd7; #1;
    check("map5_r16", 32'(Rs1_Phys), 96);
    check("map5_r8",  32'(Rs2_Phys), 88);
    check("map5_r7",  32'(Rd_Phys), 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
